// File: rtl/pc_fetch_unit.sv
// pc_fetch_unit: fetch program counter for the IF stage.
// Supplies the fetch address and its incremented value. Handles sequential
// increment, stall hold, and jump/branch redirect with bubble insertion.
// A redirect target that is not word aligned traps to TRAP_VECTOR.
// All state changes on the falling clock edge, as the pipeline registers do.
module pc_fetch_unit #(
  parameter logic [31:0] RESET_PC     = 32'h0000_0000,
  parameter logic [31:0] TRAP_VECTOR  = 32'h0000_0100,
  parameter logic [31:0] INC          = 32'd4,
  parameter int          FLUSH_CYCLES = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  input  logic        jump,
  input  logic [31:0] jump_target,
  output logic [31:0] pc_out,
  output logic [31:0] pcinc_out,
  output logic        valid,
  output logic        flush,
  output logic        misaligned,
  output logic [15:0] stall_cycles
);

  localparam logic [1:0] S_BOOT  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_STALL = 2'd2;
  localparam logic [1:0] S_FLUSH = 2'd3;

  // Bubble counter reload value: FLUSH_CYCLES bubbles means FLUSH_CYCLES-1
  // further edges after the one that accepted the redirect.
  localparam logic [2:0] FLUSH_LOAD = 3'(FLUSH_CYCLES - 1);

  logic [1:0]  state_reg, state_next;
  logic [31:0] pc_reg, pc_next;
  logic        valid_reg, valid_next;
  logic        flush_reg, flush_next;
  logic        mis_reg, mis_next;
  logic [2:0]  cnt_reg, cnt_next;
  logic [15:0] sc_reg, sc_next;

  logic        redirect;
  logic [31:0] target;
  logic        target_bad;
  logic [31:0] redirect_pc;

  // Jump outranks a taken branch; an unaligned target goes to the trap vector.
  always_comb begin
    redirect    = jump | branch_taken;
    target      = jump ? jump_target : branch_target;
    target_bad  = (target[1:0] != 2'b00);
    redirect_pc = target_bad ? TRAP_VECTOR : target;
  end

  // Next-state logic: redirect beats stall, stall beats increment.
  always_comb begin
    state_next = state_reg;
    pc_next    = pc_reg;
    valid_next = valid_reg;
    flush_next = 1'b0;
    mis_next   = 1'b0;
    cnt_next   = cnt_reg;
    sc_next    = sc_reg;

    case (state_reg)
      S_BOOT: begin
        // RESET_PC becomes the first real fetch; inputs are ignored here.
        state_next = S_RUN;
        valid_next = 1'b1;
      end

      S_RUN, S_STALL: begin
        if (state_reg == S_STALL && sc_reg != 16'hFFFF) begin
          sc_next = sc_reg + 16'd1;
        end
        if (redirect) begin
          pc_next    = redirect_pc;
          mis_next   = target_bad;
          flush_next = 1'b1;
          valid_next = 1'b0;
          cnt_next   = FLUSH_LOAD;
          state_next = S_FLUSH;
        end else if (state_reg == S_STALL) begin
          // Leaving STALL holds pc for one more edge; increment resumes after.
          if (!stall) begin
            state_next = S_RUN;
          end
        end else if (stall) begin
          state_next = S_STALL;
        end else begin
          pc_next = pc_reg + INC;
        end
      end

      S_FLUSH: begin
        if (redirect) begin
          pc_next    = redirect_pc;
          mis_next   = target_bad;
          flush_next = 1'b1;
          cnt_next   = FLUSH_LOAD;
        end else if (cnt_reg == 3'd0) begin
          // Target becomes the first valid fetch; stall only matters on exit.
          valid_next = 1'b1;
          state_next = stall ? S_STALL : S_RUN;
        end else begin
          cnt_next = cnt_reg - 3'd1;
        end
      end

      default: begin
        state_next = S_BOOT;
      end
    endcase
  end

  // State registers, updated on the falling edge; reset acts immediately.
  always_ff @(negedge clk or posedge reset) begin
    if (reset) begin
      state_reg <= S_BOOT;
      pc_reg    <= RESET_PC;
      valid_reg <= 1'b0;
      flush_reg <= 1'b0;
      mis_reg   <= 1'b0;
      cnt_reg   <= 3'd0;
      sc_reg    <= 16'd0;
    end else begin
      state_reg <= state_next;
      pc_reg    <= pc_next;
      valid_reg <= valid_next;
      flush_reg <= flush_next;
      mis_reg   <= mis_next;
      cnt_reg   <= cnt_next;
      sc_reg    <= sc_next;
    end
  end

  // Output mapping; pcinc_out wraps modulo 2^32.
  always_comb begin
    pc_out       = pc_reg;
    pcinc_out    = pc_reg + INC;
    valid        = valid_reg;
    flush        = flush_reg;
    misaligned   = mis_reg;
    stall_cycles = sc_reg;
  end

endmodule

// File: tb/tb_pc_fetch_unit.sv
// tb_pc_fetch_unit: directed plus randomized stimulus for pc_fetch_unit,
// checked against a behavioural model of the fetch rules.
module tb_pc_fetch_unit;

  localparam logic [31:0] RESET_PC    = 32'h0000_0000;
  localparam logic [31:0] TRAP_VECTOR = 32'h0000_0100;
  localparam logic [31:0] INC         = 32'd4;
  localparam int          FLUSH_CYC   = 1;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        stall = 1'b0;
  logic        branch_taken = 1'b0;
  logic [31:0] branch_target = 32'h0;
  logic        jump = 1'b0;
  logic [31:0] jump_target = 32'h0;
  logic [31:0] pc_out;
  logic [31:0] pcinc_out;
  logic        valid;
  logic        flush;
  logic        misaligned;
  logic [15:0] stall_cycles;

  int total = 0;
  int bad   = 0;

  // Behavioural model: "booting", bubbles still to emit, and "held by stall".
  logic [31:0] m_pc;
  logic        m_valid, m_flush, m_mis;
  int          m_sc;
  bit          m_boot, m_hold;
  int          m_bub;

  pc_fetch_unit #(
    .RESET_PC(RESET_PC), .TRAP_VECTOR(TRAP_VECTOR), .INC(INC), .FLUSH_CYCLES(FLUSH_CYC)
  ) dut (
    .clk(clk), .reset(reset), .stall(stall),
    .branch_taken(branch_taken), .branch_target(branch_target),
    .jump(jump), .jump_target(jump_target),
    .pc_out(pc_out), .pcinc_out(pcinc_out), .valid(valid), .flush(flush),
    .misaligned(misaligned), .stall_cycles(stall_cycles)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    m_pc = RESET_PC; m_valid = 0; m_flush = 0; m_mis = 0; m_sc = 0;
    m_boot = 1; m_hold = 0; m_bub = 0;
  endtask

  task automatic model_redirect();
    logic [31:0] t;
    t = jump ? jump_target : branch_target;
    if (t % 4 != 0) begin
      m_pc = TRAP_VECTOR; m_mis = 1;
    end else begin
      m_pc = t;
    end
    m_flush = 1; m_valid = 0; m_bub = FLUSH_CYC; m_hold = 0;
  endtask

  // One falling edge of the model, using the inputs currently driven.
  task automatic model_step();
    m_flush = 0; m_mis = 0;
    if (m_boot) begin
      m_boot = 0; m_valid = 1;
    end else if (m_bub > 0) begin
      if (jump || branch_taken) model_redirect();
      else begin
        m_bub = m_bub - 1;
        if (m_bub == 0) begin m_valid = 1; m_hold = stall; end
      end
    end else begin
      if (m_hold && m_sc < 65535) m_sc = m_sc + 1;
      if (jump || branch_taken) model_redirect();
      else if (m_hold) m_hold = stall;
      else if (stall) m_hold = 1;
      else m_pc = m_pc + INC;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    total++;
    assert (obs === exp_v) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".pc"}, pc_out, m_pc);
    chk({tag, ".pcinc"}, pcinc_out, m_pc + INC);
    chk({tag, ".valid"}, {31'b0, valid}, {31'b0, m_valid});
    chk({tag, ".flush"}, {31'b0, flush}, {31'b0, m_flush});
    chk({tag, ".mis"}, {31'b0, misaligned}, {31'b0, m_mis});
    chk({tag, ".sc"}, {16'b0, stall_cycles}, 32'(m_sc));
    $display("t=%0t %s pc=%h valid=%0b flush=%0b mis=%0b sc=%0d",
             $time, tag, pc_out, valid, flush, misaligned, stall_cycles);
  endtask

  // Drive inputs, advance one falling edge, then compare.
  task automatic cyc(input string tag, input logic s, input logic b, input logic [31:0] bt,
                     input logic j, input logic [31:0] jt);
    stall = s; branch_taken = b; branch_target = bt; jump = j; jump_target = jt;
    model_step();
    @(negedge clk);
    #2;
    check_all(tag);
  endtask

  // Asynchronous reset between edges; outputs must react without a clock.
  task automatic async_reset(input string tag);
    #1 reset = 1'b1;
    #1;
    model_reset();
    check_all(tag);
    reset = 1'b0;
    stall = 0; branch_taken = 0; jump = 0;
  endtask

  initial begin
    logic [31:0] r, tb_t, tj_t;
    model_reset();
    #13;
    check_all("reset");
    reset = 1'b0;

    // Boot and sequential fetch.
    for (int i = 0; i < 5; i++) cyc("seq", 0, 0, 0, 0, 0);      // pc 0,4,8,C,10
    // Stall three edges at 0x10, release, then resume.
    for (int i = 0; i < 3; i++) cyc("stall", 1, 0, 0, 0, 0);
    cyc("stall_rel", 0, 0, 0, 0, 0);
    cyc("resume", 0, 0, 0, 0, 0);                               // 0x14
    for (int i = 0; i < 3; i++) cyc("seq2", 0, 0, 0, 0, 0);     // to 0x20
    // Taken branch to 0x40.
    cyc("br", 0, 1, 32'h40, 0, 0);
    cyc("br_f", 0, 0, 0, 0, 0);
    cyc("br_n", 0, 0, 0, 0, 0);
    // Jump beats branch; stall ignored during flush.
    cyc("jmp", 1, 1, 32'h40, 1, 32'h80);
    cyc("jmp_f", 1, 0, 0, 0, 0);
    cyc("jmp_r", 0, 0, 0, 0, 0);
    cyc("jmp_n", 0, 0, 0, 0, 0);
    // Misaligned jump traps.
    cyc("mis", 0, 0, 0, 1, 32'h82);
    cyc("mis_f", 0, 0, 0, 0, 0);
    cyc("mis_n", 0, 0, 0, 0, 0);
    // Reset mid-flush.
    cyc("pre_rf", 0, 0, 0, 1, 32'h200);
    async_reset("rst_flush");
    cyc("boot2", 0, 0, 0, 0, 0);
    cyc("st_a", 1, 0, 0, 0, 0);
    cyc("st_b", 1, 0, 0, 0, 0);
    async_reset("rst_stall");
    // Wrap-around.
    cyc("boot3", 0, 0, 0, 0, 0);
    cyc("wrap_j", 0, 0, 0, 1, 32'hFFFF_FFFC);
    cyc("wrap_f", 0, 0, 0, 0, 0);
    cyc("wrap_0", 0, 0, 0, 0, 0);
    cyc("wrap_4", 0, 0, 0, 0, 0);

    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      r = $urandom();
      tb_t = $urandom();
      tj_t = $urandom();
      if (r[3:0] != 0) tb_t[1:0] = 2'b00;
      if (r[7:4] != 0) tj_t[1:0] = 2'b00;
      if ($urandom_range(0, 99) == 0) async_reset("rnd_rst");
      else cyc("rnd", ($urandom_range(0, 3) == 0), ($urandom_range(0, 9) == 0), tb_t,
               ($urandom_range(0, 14) == 0), tj_t);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pc_fetch_unit.md
Name: pc_fetch_unit

Overview:
- Generates the fetch program counter and its incremented value for the IF stage.
- Its pcinc_out is the producer-side value captured by the IF/ID PC-increment pipeline register.
- Handles sequential increment, stall hold, branch/jump redirect with bubble insertion, and misaligned-target trap.
- Sits between hazard/branch-resolution logic (inputs) and instruction memory plus IF/ID pipeline registers (outputs).

Parameters:
- RESET_PC, 32'h0000_0000, first fetch address after reset.
- TRAP_VECTOR, 32'h0000_0100, fetch address used when a redirect target is misaligned.
- INC, 4, PC increment in bytes.
- FLUSH_CYCLES, 1, bubble cycles (valid low) after any redirect; legal range 1..7.

Ports:
- clk  in  1  clock; all state updates on the falling edge, as for the pipeline registers.
- reset  in  1  asynchronous, active-high reset.
- stall  in  1  hazard unit hold request.
- branch_taken  in  1  conditional branch resolved taken.
- branch_target  in  32  branch destination.
- jump  in  1  unconditional jump request.
- jump_target  in  32  jump destination.
- pc_out  out  32  current fetch address.
- pcinc_out  out  32  pc_out + INC, combinational from pc_out, modulo 2^32.
- valid  out  1  pc_out is a real fetch; low means bubble.
- flush  out  1  one-cycle pulse telling downstream registers to squash.
- misaligned  out  1  one-cycle pulse when a redirect target has bits [1:0] != 0.
- stall_cycles  out  16  saturating count of falling edges spent in STALL.

Behaviour:
- Reset (asynchronous, any time, including mid-flush or mid-stall):
  - pc_out = RESET_PC, pcinc_out = RESET_PC+INC.
  - valid = 0, flush = 0, misaligned = 0, stall_cycles = 0.
  - Flush counter = 0, state = BOOT.
- States: BOOT, RUN, STALL, FLUSH. All transitions occur on the falling edge of clk.
- BOOT: first edge with reset low -> RUN, valid = 1, pc unchanged, so RESET_PC is the first fetch. Inputs are ignored in BOOT.
- Redirect priority: jump > branch_taken. The chosen target is jump_target when jump = 1, else branch_target.
- Input priority in RUN and STALL: redirect > stall > increment.
- RUN:
  - Redirect: if target[1:0] != 0, pc <= TRAP_VECTOR and misaligned <= 1; else pc <= target. Also flush <= 1, valid <= 0, counter <= FLUSH_CYCLES-1, state -> FLUSH.
  - Else if stall: pc holds, valid stays 1, state -> STALL.
  - Else: pc <= pc + INC.
- STALL:
  - stall_cycles increments by 1 each edge spent in STALL, saturating at 16'hFFFF.
  - Redirect is handled exactly as in RUN.
  - stall = 0 -> RUN with pc held; increment resumes on the following edge.
- FLUSH:
  - pc holds the redirect target, valid = 0, and stall is ignored.
  - Counter = 0 -> valid <= 1; state -> STALL if stall is high, else RUN. The target becomes the first valid fetch.
  - A new redirect in FLUSH reloads pc with the new target, re-pulses flush (and misaligned if applicable), and reloads the counter.
- flush and misaligned are high for exactly one cycle per accepted redirect and are cleared on the next edge unless re-triggered.
- Arithmetic: 32-bit unsigned with no overflow flag. 32'hFFFF_FFFC + 4 = 32'h0000_0000.

Test Plan:
- Reset release, no other inputs -> edge1: valid=1, pc=0x0. Edges 2..4: pc=0x4, 0x8, 0xC. pcinc_out always = pc+4.
- stall high 3 edges at pc=0x10 -> pc stays 0x10, valid=1, stall_cycles=3. After release, next edge pc=0x14.
- branch_taken with target 0x40 at pc=0x20 -> pc=0x40, flush=1 for one cycle, valid=0 one cycle, then valid=1 with pc=0x40, then 0x44.
- jump=1 target 0x80 together with branch_taken target 0x40 and stall=1 -> pc=0x80; stall ignored during FLUSH.
- jump target 0x82 -> pc=0x100, misaligned=1 and flush=1 for exactly one cycle.
- Reset asserted mid-FLUSH and mid-STALL -> all outputs return to reset values immediately without a clock edge. pc=0xFFFF_FFFC incrementing -> wraps to 0x0.
